cmd_frame_rx: RTL and testbench
===============================

CMD_FRAME_RX -- requirements
Module: cmd_frame_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: clk cycles per serial bit; even, at least 4.
REQ-002 Parameter BYTE_TIMEOUT, default 320: maximum idle clk cycles allowed between the command byte and the address byte.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 serialIn  input  1  asynchronous 8N1 line from the PC; idles high.
REQ-006 clearCmd  input  1  consumer acknowledge; releases the held command.
REQ-007 commandOut  output  8  command byte of the last accepted frame; 8'hFF when no command is held.
REQ-008 addressOut  output  8  sensor address byte of the last accepted frame.
REQ-009 cmdValid  output  1  high while a command/address pair is held.
REQ-010 frameError  output  1  one-cycle pulse on a stop-bit error, range error or inter-byte timeout.
REQ-011 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-012 serialIn shall pass through a 2-flop synchronizer; all later references mean the synchronized value.
REQ-013 Bit FSM states shall be IDLE, START, DATA and STOP.
REQ-014 IDLE: a sampled 0 shall enter START and clear the bit counter.
REQ-015 START: at count OVERSAMPLE/2-1, a sampled 1 shall return to IDLE (glitch, no error); a sampled 0 shall enter DATA with the counter cleared.
REQ-016 DATA: every OVERSAMPLE cycles, sample one bit and shift it in LSB first; after the 8th bit, enter STOP.
REQ-017 STOP: after OVERSAMPLE cycles, a sampled 1 accepts the byte; a sampled 0 pulses frameError, discards the byte and any pending command byte, and returns to IDLE.
REQ-018 The frame shall be two bytes, command then address, tracked by a byteSel flag (0 = expecting command).
REQ-019 Accepted byte with byteSel=0: store it as the pending command, set byteSel=1, clear the timeout counter.
REQ-020 Timeout: while byteSel=1 and the bit FSM is in IDLE, the timeout counter increments; on reaching BYTE_TIMEOUT, set byteSel=0, drop the pending command and pulse frameError.
REQ-021 Accepted byte with byteSel=1: complete the frame and set byteSel=0.
REQ-022 On frame completion, commandOut, addressOut and cmdValid=1 shall update on the clk edge after the stop-bit sample.
REQ-023 Frame completion while cmdValid=1 and clearCmd=0: outputs unchanged, overrun pulses, new frame dropped.
REQ-024 clearCmd=1 with cmdValid=1 and no completion: the next cycle gives cmdValid=0 and commandOut=8'hFF; addressOut keeps its value.
REQ-025 clearCmd=1 in the same cycle as a frame completion: the new frame loads, cmdValid stays 1, no overrun.
REQ-026 clearCmd while cmdValid=0 shall have no effect.
REQ-027 Reception shall continue while a command is held; the bit FSM never stalls.

Reset
REQ-028 rst=1 at a clk edge shall set: FSM=IDLE; byteSel=0; all counters 0; shift register 0; commandOut=8'hFF; addressOut=8'h00; cmdValid=0; frameError=0; overrun=0; synchronizer flops=1.
REQ-029 rst asserted mid-byte or mid-frame shall discard all partial data; the first start bit after reset is treated as a command byte.

Configuration
REQ-030 With macro CMD_RANGE_CHECK_EN defined: a command byte greater than 8'h06 is rejected at its stop bit, pulses frameError and keeps byteSel=0.
REQ-031 With CMD_RANGE_CHECK_EN undefined: any command byte value is accepted.

Verification
REQ-032 Send 8'h01 then 8'h05 with OVERSAMPLE=16 -> cmdValid=1, commandOut=8'h01, addressOut=8'h05 one cycle after the second stop sample.
REQ-033 Hold a frame; pulse clearCmd one cycle -> next cycle cmdValid=0, commandOut=8'hFF, addressOut=8'h05.
REQ-034 Send 8'h02 with stop bit 0 -> frameError pulses once, cmdValid stays 0; a following good frame 8'h02/8'h03 is accepted.
REQ-035 Send 8'h03, then idle for 321 cycles, then 8'h04/8'h07 -> frameError at the timeout; 8'h04 is treated as a command and the result is commandOut=8'h04, addressOut=8'h07.
REQ-036 Complete a second frame while the first is held with no clearCmd -> overrun pulses, outputs keep the first frame; repeat with clearCmd on the completion cycle -> second frame loaded, no overrun.
REQ-037 With CMD_RANGE_CHECK_EN defined, send 8'h09/8'h01 -> frameError, no cmdValid; 8'h01 is taken as a pending command.

Source files
------------

// File: rtl/cmd_frame_rx_if.sv
// Bus bundle for cmd_frame_rx: serial line and clear in, held command/address and status pulses out.
interface cmd_frame_rx_if;
    logic       serialIn;
    logic       clearCmd;
    logic [7:0] commandOut;
    logic [7:0] addressOut;
    logic       cmdValid;
    logic       frameError;
    logic       overrun;

    modport slave (
        input  serialIn,
        input  clearCmd,
        output commandOut,
        output addressOut,
        output cmdValid,
        output frameError,
        output overrun
    );

    modport master (
        output serialIn,
        output clearCmd,
        input  commandOut,
        input  addressOut,
        input  cmdValid,
        input  frameError,
        input  overrun
    );
endinterface

// File: rtl/cmd_frame_rx.sv
// 8N1 receiver that assembles two-byte command/address frames and holds them until cleared.
// Optional macro CMD_RANGE_CHECK_EN rejects command bytes above 8'h06.
module cmd_frame_rx #(
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned BYTE_TIMEOUT = 320
) (
    input  logic          clk,
    input  logic          rst,
    cmd_frame_rx_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned TMO_W = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BYTE_TIMEOUT - 1);
`ifdef CMD_RANGE_CHECK_EN
    localparam logic [7:0] MAX_CMD = 8'h06;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

    stateT            state;
    stateT            nextState;
    logic             syncA;
    logic             syncB;
    logic [CNT_W-1:0] bitCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             byteSel;
    logic [7:0]       pendingCmd;
    logic [TMO_W-1:0] tmoCnt;

    logic sampleTick;
    logic cntClr;
    logic stopOk;
    logic stopErr;
    logic rangeErr;
    logic cmdAccept;
    logic frameDone;
    logic timeoutHit;
    logic loadFrame;
    logic dropFrame;
    logic releaseCmd;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (!syncB) nextState = START;
            START: if (bitCnt == HALF_CNT) nextState = syncB ? IDLE : DATA;
            DATA:  if (sampleTick && bitIdx == 3'd7) nextState = STOP;
            STOP:  if (sampleTick) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Per-cycle decode of sample points and frame-level events.
    always_comb begin
        sampleTick = (bitCnt == FULL_CNT);
        cntClr     = 1'b0;
        stopOk     = 1'b0;
        stopErr    = 1'b0;
        case (state)
            IDLE:  cntClr = 1'b1;
            START: cntClr = (bitCnt == HALF_CNT);
            DATA:  cntClr = sampleTick;
            STOP: begin
                cntClr  = sampleTick;
                stopOk  = sampleTick && syncB;
                stopErr = sampleTick && !syncB;
            end
            default: cntClr = 1'b1;
        endcase
`ifdef CMD_RANGE_CHECK_EN
        rangeErr   = stopOk && !byteSel && (shiftReg > MAX_CMD);
`else
        rangeErr   = 1'b0;
`endif
        cmdAccept  = stopOk && !byteSel && !rangeErr;
        frameDone  = stopOk && byteSel;
        timeoutHit = byteSel && (state == IDLE) && (tmoCnt == TMO_LAST);
        loadFrame  = frameDone && (!bus.cmdValid || bus.clearCmd);
        dropFrame  = frameDone && bus.cmdValid && !bus.clearCmd;
        releaseCmd = bus.clearCmd && bus.cmdValid && !frameDone;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            syncA          <= 1'b1;
            syncB          <= 1'b1;
            bitCnt         <= '0;
            bitIdx         <= '0;
            shiftReg       <= '0;
            byteSel        <= 1'b0;
            pendingCmd     <= '0;
            tmoCnt         <= '0;
            bus.commandOut <= 8'hFF;
            bus.addressOut <= 8'h00;
            bus.cmdValid   <= 1'b0;
            bus.frameError <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            syncA  <= bus.serialIn;
            syncB  <= syncA;
            bitCnt <= cntClr ? '0 : bitCnt + CNT_W'(1);

            if (state == START)                 bitIdx <= '0;
            else if (state == DATA && sampleTick) bitIdx <= bitIdx + 3'd1;

            // LSB arrives first, so shift right and insert at the top.
            if (state == DATA && sampleTick) shiftReg <= {syncB, shiftReg[7:1]};

            if (cmdAccept) begin
                byteSel    <= 1'b1;
                pendingCmd <= shiftReg;
            end else if (frameDone || stopErr || timeoutHit) begin
                byteSel <= 1'b0;
            end

            if (cmdAccept || timeoutHit)         tmoCnt <= '0;
            else if (byteSel && state == IDLE)   tmoCnt <= tmoCnt + TMO_W'(1);

            bus.frameError <= stopErr || rangeErr || timeoutHit;
            bus.overrun    <= dropFrame;

            if (loadFrame) begin
                bus.commandOut <= pendingCmd;
                bus.addressOut <= shiftReg;
                bus.cmdValid   <= 1'b1;
            end else if (releaseCmd) begin
                bus.commandOut <= 8'hFF;
                bus.cmdValid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cmd_frame_rx.sv
// Self-checking bench for cmd_frame_rx: table of frames plus hand-written corner sequences.
module tb_cmd_frame_rx;
    localparam int unsigned OS  = 16;
    localparam int unsigned TMO = 320;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmd_frame_rx_if bus();

    cmd_frame_rx #(.OVERSAMPLE(OS), .BYTE_TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         n;          // bytes sent (1..3)
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        bit         bad0;       // first byte gets a 0 stop bit
        int         gap;        // idle cycles after first byte
        bit         preClr;     // pulse clearCmd before sending
        bit         clrAtDone;  // clearCmd on the last stop-sample edge
        bit         chkTime;    // exact load latency check on last byte
        bit         expLoad;
        logic [7:0] expCmd;
        logic [7:0] expAddr;
        int         expErr;
        int         expOvr;
        bit         finValid;
        logic [7:0] finCmd;
        logic [7:0] finAddr;
    } vecT;

    int totalCnt = 0;
    int passCnt  = 0;
    int errCnt   = 0;
    int ovrCnt   = 0;
    logic [15:0] expQ[$];
    logic       prevValid;
    logic [7:0] prevCmd;
    logic [7:0] prevAddr;
    vecT vecs[6];

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseClear();
        bus.clearCmd = 1'b1;
        tick(1);
        bus.clearCmd = 1'b0;
        tick(1);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit stopVal, input bit clrAtStop, input bit chkTime);
        bus.serialIn = 1'b0;
        tick(OS);
        for (int i = 0; i < 8; i++) begin
            bus.serialIn = b[i];
            tick(OS);
        end
        bus.serialIn = stopVal;
        // Stop is sampled mid-bit, 2 sync cycles plus half a bit after it is driven.
        tick(2 + OS / 2);
        if (chkTime) check("valid before stop sample", int'(bus.cmdValid), 0);
        if (clrAtStop) bus.clearCmd = 1'b1;
        tick(1);
        bus.clearCmd = 1'b0;
        if (chkTime) check("valid one cycle after stop sample", int'(bus.cmdValid), 1);
        tick(OS - 3 - OS / 2);
        bus.serialIn = 1'b1;
    endtask

    task automatic checkHeld(input string tag, input bit v, input logic [7:0] c, input logic [7:0] a);
        check({tag, " cmdValid"}, int'(bus.cmdValid), int'(v));
        check({tag, " commandOut"}, int'(bus.commandOut), int'(c));
        check({tag, " addressOut"}, int'(bus.addressOut), int'(a));
    endtask

    task automatic runVec(input int idx, input vecT v);
        int e0;
        int o0;
        string tag;
        tag = $sformatf("v%0d", idx);
        e0 = errCnt;
        o0 = ovrCnt;
        if (v.preClr) pulseClear();
        if (v.expLoad) expQ.push_back({v.expCmd, v.expAddr});
        sendByte(v.b0, !v.bad0, v.n == 1 && v.clrAtDone, v.n == 1 && v.chkTime);
        if (v.gap > 0) tick(v.gap);
        if (v.n >= 2) sendByte(v.b1, 1'b1, v.n == 2 && v.clrAtDone, v.n == 2 && v.chkTime);
        if (v.n >= 3) sendByte(v.b2, 1'b1, v.clrAtDone, v.chkTime);
        tick(2 * OS);
        check({tag, " frameError pulses"}, errCnt - e0, v.expErr);
        check({tag, " overrun pulses"}, ovrCnt - o0, v.expOvr);
        check({tag, " outstanding loads"}, expQ.size(), 0);
        checkHeld(tag, v.finValid, v.finCmd, v.finAddr);
        expQ.delete();
    endtask

    // Output monitor: counts pulses and pops the scoreboard on every new frame load.
    initial begin
        logic [15:0] e;
        prevValid = 1'b0;
        prevCmd   = 8'hFF;
        prevAddr  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevValid = 1'b0;
                prevCmd   = 8'hFF;
                prevAddr  = 8'h00;
            end else begin
                if (bus.frameError) errCnt++;
                if (bus.overrun) ovrCnt++;
                if (bus.cmdValid && (!prevValid || bus.commandOut != prevCmd || bus.addressOut != prevAddr)) begin
                    if (expQ.size() == 0) begin
                        totalCnt++;
                        $display("FAIL unexpected load: got %h/%h, no load expected", bus.commandOut, bus.addressOut);
                    end else begin
                        e = expQ.pop_front();
                        check("load commandOut", int'(bus.commandOut), int'(e[15:8]));
                        check("load addressOut", int'(bus.addressOut), int'(e[7:0]));
                    end
                end
                prevValid = bus.cmdValid;
                prevCmd   = bus.commandOut;
                prevAddr  = bus.addressOut;
            end
        end
    end

    initial begin
        int e0;
        //            n  b0     b1     b2     bad gap  pre clr chk load eCmd   eAddr  err ovr fV fCmd   fAddr
        vecs[0] = '{2, 8'h01, 8'h05, 8'h00, 0, 0,   1,  0,  1,  1,   8'h01, 8'h05, 0,  0,  1, 8'h01, 8'h05};
        vecs[1] = '{3, 8'h02, 8'h02, 8'h03, 1, 32,  1,  0,  0,  1,   8'h02, 8'h03, 1,  0,  1, 8'h02, 8'h03};
        vecs[2] = '{2, 8'h04, 8'h0B, 8'h00, 0, 0,   0,  0,  0,  0,   8'h00, 8'h00, 0,  1,  1, 8'h02, 8'h03};
        vecs[3] = '{2, 8'h05, 8'h0D, 8'h00, 0, 0,   0,  1,  0,  1,   8'h05, 8'h0D, 0,  0,  1, 8'h05, 8'h0D};
        vecs[4] = '{3, 8'h03, 8'h04, 8'h07, 0, 321, 1,  0,  0,  1,   8'h04, 8'h07, 1,  0,  1, 8'h04, 8'h07};
`ifdef CMD_RANGE_CHECK_EN
        vecs[5] = '{3, 8'h09, 8'h01, 8'h22, 0, 0,   1,  0,  0,  1,   8'h01, 8'h22, 1,  0,  1, 8'h01, 8'h22};
`else
        vecs[5] = '{3, 8'h09, 8'h01, 8'h22, 0, 0,   1,  0,  0,  1,   8'h09, 8'h01, 0,  0,  1, 8'h09, 8'h01};
`endif

        rst = 1'b1;
        bus.serialIn = 1'b1;
        bus.clearCmd = 1'b0;
        tick(3);
        checkHeld("reset", 1'b0, 8'hFF, 8'h00);
        check("reset frameError", int'(bus.frameError), 0);
        check("reset overrun", int'(bus.overrun), 0);
        rst = 1'b0;
        tick(OS);

        runVec(0, vecs[0]);

        // clearCmd releases the held pair on the next cycle; address is retained.
        bus.clearCmd = 1'b1;
        tick(1);
        bus.clearCmd = 1'b0;
        checkHeld("clear", 1'b0, 8'hFF, 8'h05);
        tick(OS);

        for (int i = 1; i < 5; i++) runVec(i, vecs[i]);

        // Reset in the middle of a frame discards the pending command.
        e0 = errCnt;
        sendByte(8'h06, 1'b1, 1'b0, 1'b0);
        bus.serialIn = 1'b0;
        tick(3 * OS);
        rst = 1'b1;
        bus.serialIn = 1'b1;
        tick(2);
        rst = 1'b0;
        checkHeld("mid-frame reset", 1'b0, 8'hFF, 8'h00);
        tick(2 * OS);
        expQ.push_back(16'h0213);
        sendByte(8'h02, 1'b1, 1'b0, 1'b0);
        sendByte(8'h13, 1'b1, 1'b0, 1'b0);
        tick(2 * OS);
        check("after reset outstanding loads", expQ.size(), 0);
        checkHeld("after reset", 1'b1, 8'h02, 8'h13);
        check("after reset frameError pulses", errCnt - e0, 0);

        // Short low glitch is rejected at the start-bit midpoint without error.
        e0 = errCnt;
        bus.serialIn = 1'b0;
        tick(3);
        bus.serialIn = 1'b1;
        tick(2 * OS);
        check("glitch frameError pulses", errCnt - e0, 0);
        checkHeld("glitch", 1'b1, 8'h02, 8'h13);

        runVec(5, vecs[5]);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
